// File: rtl/rom_bus_ctrl.sv
// -----------------------------------------------------------------------------
// rom_bus_ctrl
//   CPU-side access controller in front of a synchronous (1-clock registered
//   read) boot ROM. Decodes the 6502 address bus, drives the ROM CS_N/OE_N/A
//   pins, holds the CPU with RDY low while a ROM read is in flight, captures
//   the ROM byte into a CPU-facing register and pulses ACK for one cycle.
//
//   Access timeline (edge e0 = accepting edge, W = WAIT_STATES):
//     e0           IDLE   -> STROBE  ROM_A latched, strobes/RDY go low
//     e1           STROBE -> WAIT/CAPT  ROM registers mem[ROM_A]
//     e1..e1+W     WAIT   (W cycles)
//     e2+W         CAPT   -> DONE    CPU_DO <= ROM_DO, strobes/RDY high, ACK high
//     e3+W         DONE   -> IDLE    CPU samples ACK here
//   An accepted write goes IDLE -> DONE directly (ACK sampled one edge later).
//
// Ports
//   CLK       in   1           system clock, posedge
//   RESET_N   in   1           asynchronous active-low reset
//   CPU_A     in   16          CPU address
//   CPU_RW    in   1           1 = read, 0 = write
//   CPU_REQ   in   1           access request level
//   CPU_DO    out  DATA_WIDTH  registered read data
//   CPU_ACK   out  1           one-cycle completion pulse
//   CPU_RDY   out  1           low while a ROM read is in progress
//   HIT       out  1           combinational window decode of CPU_A
//   ROM_A     out  ADDR_WIDTH  registered ROM address
//   ROM_CS_N  out  1           ROM chip select, active low, registered
//   ROM_OE_N  out  1           ROM output enable, active low, registered
//   ROM_DO    in   DATA_WIDTH  ROM data
//   WR_ERR    out  1           sticky write-to-ROM flag
//   ERR_ADDR  out  16          address of the first offending write
//
// Configuration
//   ROM_BUS_CTRL_WRERR_EN  defined: accepted writes set WR_ERR (sticky) and the
//                          first one records its address in ERR_ADDR.
//                          undefined: WR_ERR / ERR_ADDR tied to zero.
//   WAIT_STATES is limited to 0..15 (4-bit hold counter).
// -----------------------------------------------------------------------------
module rom_bus_ctrl #(
  parameter int          ADDR_WIDTH  = 14,
  parameter int          DATA_WIDTH  = 8,
  parameter logic [15:0] BASE_ADDR   = 16'hC000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [15:0]           CPU_A,
  input  logic                  CPU_RW,
  input  logic                  CPU_REQ,
  output logic [DATA_WIDTH-1:0] CPU_DO,
  output logic                  CPU_ACK,
  output logic                  CPU_RDY,
  output logic                  HIT,
  output logic [ADDR_WIDTH-1:0] ROM_A,
  output logic                  ROM_CS_N,
  output logic                  ROM_OE_N,
  input  logic [DATA_WIDTH-1:0] ROM_DO,
  output logic                  WR_ERR,
  output logic [15:0]           ERR_ADDR
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STROBE = 3'd1,
    WAIT   = 3'd2,
    CAPT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Counter reload value; guarded so WAIT_STATES == 0 never underflows.
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] rom_a_q, rom_a_d;
  logic [DATA_WIDTH-1:0] do_q, do_d;
  logic                  ack_q, rdy_q, cs_n_q, oe_n_q;
  logic                  busy_d;

  // Window decode: upper address bits against the aligned base.
  assign HIT = (CPU_A[15:ADDR_WIDTH] == BASE_ADDR[15:ADDR_WIDTH]);

  // Next-state, hold counter, address latch and read-data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rom_a_d = rom_a_q;
    do_d    = do_q;
    case (state_q)
      IDLE: begin
        if (CPU_REQ && HIT) begin
          if (CPU_RW) begin
            state_d = STROBE;
            rom_a_d = CPU_A[ADDR_WIDTH-1:0];
          end else begin
            // Writes to ROM complete without touching the ROM pins.
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      STROBE: begin
        if (WAIT_STATES > 0) begin
          state_d = WAIT;
          cnt_d   = WS_LOAD;
        end else begin
          state_d = CAPT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = CAPT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CAPT: begin
        // ROM output was registered at the STROBE exit edge and is still
        // enabled here, so it is safe to capture on this exit edge.
        do_d    = ROM_DO;
        state_d = DONE;
      end
      DONE: begin
        // REQ deliberately ignored: the next access starts from IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes and RDY are registered from the next state so they change on the
  // same edge as the state register.
  assign busy_d = (state_d == STROBE) || (state_d == WAIT) || (state_d == CAPT);

  // State, datapath and registered pin outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rom_a_q <= '0;
      do_q    <= '0;
      ack_q   <= 1'b0;
      rdy_q   <= 1'b1;
      cs_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rom_a_q <= rom_a_d;
      do_q    <= do_d;
      ack_q   <= (state_d == DONE);
      rdy_q   <= ~busy_d;
      cs_n_q  <= ~busy_d;
      oe_n_q  <= ~busy_d;
    end
  end

  assign CPU_DO   = do_q;
  assign CPU_ACK  = ack_q;
  assign CPU_RDY  = rdy_q;
  assign ROM_A    = rom_a_q;
  assign ROM_CS_N = cs_n_q;
  assign ROM_OE_N = oe_n_q;

`ifdef ROM_BUS_CTRL_WRERR_EN
  logic        wr_err_q, wr_err_d;
  logic [15:0] err_addr_q, err_addr_d;
  logic        wr_accept_s;

  assign wr_accept_s = (state_q == IDLE) && CPU_REQ && HIT && !CPU_RW;

  // Sticky error flag; only the first offending address is kept.
  always_comb begin
    wr_err_d   = wr_err_q;
    err_addr_d = err_addr_q;
    if (wr_accept_s) begin
      wr_err_d = 1'b1;
      if (!wr_err_q) begin
        err_addr_d = CPU_A;
      end else begin
        err_addr_d = err_addr_q;
      end
    end else begin
      wr_err_d = wr_err_q;
    end
  end

  // Error flag and address registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_err_q   <= 1'b0;
      err_addr_q <= 16'h0000;
    end else begin
      wr_err_q   <= wr_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign WR_ERR   = wr_err_q;
  assign ERR_ADDR = err_addr_q;
`else
  assign WR_ERR   = 1'b0;
  assign ERR_ADDR = 16'h0000;
`endif

endmodule
